// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mdu_pkg                                                   |
// | Purpose  : Shared definitions for the MDU controller: operation      |
// |            encodings, default latencies and the FSM state type.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mdu_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
   localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
   localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
   localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
   localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
   localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

   localparam int unsigned MULT_CYC_DEF = 5;
   localparam int unsigned DIV_CYC_DEF  = 10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mdu_if                                                    |
// | Purpose  : Pipeline-to-MDU signal bundle.                            |
// |   master : drives start/op/a/b/cancel/dUsesMdu, observes results     |
// |   slave  : the MDU controller; returns busy/stall/hi/lo              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface mdu_if;
   import mdu_pkg::*;

   logic            start;     // E-stage MDU instruction valid
   logic [OP_W-1:0] op;        // operation select
   logic [31:0]     a;         // rs operand (forwarded)
   logic [31:0]     b;         // rt operand (forwarded)
   logic            cancel;    // flush of the E-stage instruction
   logic            dUsesMdu;  // D-stage instruction touches the MDU
   logic            busy;      // operation in flight
   logic            stall;     // D-stage stall request
   logic [31:0]     hi;        // HI register
   logic [31:0]     lo;        // LO register

   modport master (
      output start, op, a, b, cancel, dUsesMdu,
      input  busy, stall, hi, lo
   );

   modport slave (
      input  start, op, a, b, cancel, dUsesMdu,
      output busy, stall, hi, lo
   );

endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mdu_ctrl                                                  |
// | Purpose  : Multiply/divide unit controller with HI/LO registers.     |
// |            The result is computed behaviourally when the operation   |
// |            is accepted and committed to HI/LO after a fixed latency  |
// |            modelled by a down-counter.                               |
// | Ports    : clk   - rising-edge clock                                 |
// |            reset - synchronous active-high reset                     |
// |            bus   - mdu_if.slave (start/op/a/b/cancel/dUsesMdu in,    |
// |                    busy/stall/hi/lo out)                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYC = MULT_CYC_DEF,
   parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

   localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [63:0]      res_q,   res_d;     // pending {hi,lo}
   logic             res_wr_q, res_wr_d; // pending result is to be written
   logic [31:0]      hi_q,    hi_d;
   logic [31:0]      lo_q,    lo_d;

   logic               accept;
   logic [63:0]        calc;
   logic               calc_wr;
   logic signed [63:0] a_sx, b_sx;
   logic signed [31:0] a_s, b_s, q_s, r_s;

   // ------------------------------------------------------------------
   // Behavioural arithmetic on the operands presented with start
   // ------------------------------------------------------------------
   always_comb begin
      a_s     = signed'(bus.a);
      b_s     = signed'(bus.b);
      a_sx    = {{32{bus.a[31]}}, bus.a};
      b_sx    = {{32{bus.b[31]}}, bus.b};
      q_s     = '0;
      r_s     = '0;
      calc    = '0;
      calc_wr = 1'b0;
      case (bus.op)
         OP_MULT: begin
            calc    = a_sx * b_sx;
            calc_wr = 1'b1;
         end
         OP_MULTU: begin
            calc    = {32'd0, bus.a} * {32'd0, bus.b};
            calc_wr = 1'b1;
         end
         OP_DIV: begin
            // Divide by zero leaves HI/LO untouched.
            if (bus.b != 32'd0) begin
               // The one overflowing case is pinned explicitly rather than
               // relying on simulator/synthesis behaviour of signed overflow.
               if (bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF) begin
                  q_s = signed'(32'h8000_0000);
                  r_s = '0;
               end else begin
                  q_s = a_s / b_s;
                  r_s = a_s % b_s;
               end
               calc    = {r_s, q_s};
               calc_wr = 1'b1;
            end
         end
         OP_DIVU: begin
            if (bus.b != 32'd0) begin
               calc    = {bus.a % bus.b, bus.a / bus.b};
               calc_wr = 1'b1;
            end
         end
         default: begin
            calc    = '0;
            calc_wr = 1'b0;
         end
      endcase
   end

   assign accept = bus.start & ~bus.cancel & (state_q == ST_IDLE) & (bus.op <= OP_MTLO);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         res_q    <= '0;
         res_wr_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         res_wr_q <= res_wr_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      res_wr_d = res_wr_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (bus.op)
                  OP_MTHI: hi_d = bus.a;
                  OP_MTLO: lo_d = bus.a;
                  OP_MULT, OP_MULTU: begin
                     res_d    = calc;
                     res_wr_d = calc_wr;
                     cnt_d    = CNT_W'(MULT_CYC);
                     state_d  = ST_BUSY;
                  end
                  default: begin
                     res_d    = calc;
                     res_wr_d = calc_wr;
                     cnt_d    = CNT_W'(DIV_CYC);
                     state_d  = ST_BUSY;
                  end
               endcase
            end
         end
         ST_BUSY: begin
            // Counter value 1 marks the last busy cycle; commit on its edge.
            if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               res_wr_d = 1'b0;
               if (res_wr_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.busy  = (state_q == ST_BUSY);
   assign bus.stall = bus.dUsesMdu &
                      ((state_q == ST_BUSY) | (bus.start & ~bus.cancel & (bus.op <= OP_DIVU)));
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule
`default_nettype wire
